// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default widths for the IFU/LSU memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int ADDR_W_DEF = 64;
  localparam int DATA_W_DEF = 64;
  localparam int WLEN_W     = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arb_grant.sv
// Grant selection between IFU and LSU: LSU priority, bounded by a streak
// counter that forces an IFU grant after LSU_BURST_MAX LSU wins in a row.
module mem_arb_grant
  import mem_port_arbiter_pkg::*;
#(
  parameter int LSU_BURST_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ifu_vld,
  input  logic lsu_vld,
  input  logic idle,
  input  logic hs,
  output logic grant_vld,
  output logic grant_owner
);

  localparam int SW = $clog2(LSU_BURST_MAX + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(LSU_BURST_MAX);

  logic [SW-1:0] streak;
  logic          lsu_wins;

  assign lsu_wins    = lsu_vld && !(ifu_vld && (streak == STREAK_MAX));
  assign grant_vld   = idle && (ifu_vld || lsu_vld);
  assign grant_owner = lsu_wins ? OWN_LSU : OWN_IFU;

  // The streak only counts LSU wins that actually made the IFU wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak <= '0;
    end else if (hs) begin
      if (!lsu_wins) begin
        streak <= '0;
      end else if (ifu_vld && (streak != STREAK_MAX)) begin
        streak <= streak + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between IFU and LSU: one outstanding transaction,
// request latched into registered oMem* fields, response routed to its owner.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int DATA_W        = DATA_W_DEF,
  parameter int LSU_BURST_MAX = 4
) (
  input  logic              iClock,
  input  logic              iResetN,
  input  logic              iIfuReqValid,
  output logic              oIfuReqReady,
  input  logic [ADDR_W-1:0] iIfuAddr,
  output logic              oIfuRespValid,
  input  logic              iIfuRespReady,
  output logic [DATA_W-1:0] oIfuRespData,
  input  logic              iLsuReqValid,
  output logic              oLsuReqReady,
  input  logic [ADDR_W-1:0] iLsuAddr,
  input  logic              iLsuWrEn,
  input  logic [DATA_W-1:0] iLsuWrData,
  input  logic [WLEN_W-1:0] iLsuWrLen,
  output logic              oLsuRespValid,
  input  logic              iLsuRespReady,
  output logic [DATA_W-1:0] oLsuRespData,
  output logic              oMemReqValid,
  input  logic              iMemReqReady,
  output logic [ADDR_W-1:0] oMemAddr,
  output logic              oMemWrEn,
  output logic [DATA_W-1:0] oMemWrData,
  output logic [WLEN_W-1:0] oMemWrLen,
  input  logic              iMemRespValid,
  output logic              oMemRespReady,
  input  logic [DATA_W-1:0] iMemRespData,
  output logic              oBusy
);

  arb_state_e        state, state_nxt;
  owner_e            owner_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic              wren_p0;
  logic [DATA_W-1:0] wdata_p0;
  logic [WLEN_W-1:0] wlen_p0;
  logic [DATA_W-1:0] rdata_p1;
  logic              idle, grant_vld, grant_owner, accept, resp_ready;

  assign idle = (state == IDLE);

  mem_arb_grant #(
    .LSU_BURST_MAX(LSU_BURST_MAX)
  ) u_grant (
    .clk        (iClock),
    .rst_n      (iResetN),
    .ifu_vld    (iIfuReqValid),
    .lsu_vld    (iLsuReqValid),
    .idle       (idle),
    .hs         (accept),
    .grant_vld  (grant_vld),
    .grant_owner(grant_owner)
  );

  // Readies are gated by reset so nothing handshakes while iResetN is low.
  assign oIfuReqReady = iResetN && grant_vld && (grant_owner == OWN_IFU);
  assign oLsuReqReady = iResetN && grant_vld && (grant_owner == OWN_LSU);
  assign accept       = oIfuReqReady || oLsuReqReady;
  assign resp_ready   = (owner_p0 == OWN_IFU) ? iIfuRespReady : iLsuRespReady;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)        state_nxt = ISSUE;
      ISSUE:   if (iMemReqReady)  state_nxt = WAIT;
      WAIT:    if (iMemRespValid) state_nxt = RESP;
      RESP:    if (resp_ready)    state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge iClock or negedge iResetN) begin
    if (!iResetN) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Stage p0: request latch at accept; stage p1: memory response capture.
  always_ff @(posedge iClock or negedge iResetN) begin
    if (!iResetN) begin
      owner_p0 <= OWN_IFU;
      addr_p0  <= '0;
      wren_p0  <= 1'b0;
      wdata_p0 <= '0;
      wlen_p0  <= '0;
      rdata_p1 <= '0;
    end else begin
      if (accept) begin
        if (oLsuReqReady) begin
          owner_p0 <= OWN_LSU;
          addr_p0  <= iLsuAddr;
          wren_p0  <= iLsuWrEn;
          wdata_p0 <= iLsuWrData;
          wlen_p0  <= iLsuWrLen;
        end else begin
          owner_p0 <= OWN_IFU;
          addr_p0  <= iIfuAddr;
          wren_p0  <= 1'b0;
          wdata_p0 <= '0;
          wlen_p0  <= '0;
        end
      end
      if ((state == WAIT) && iMemRespValid) begin
        rdata_p1 <= iMemRespData;
      end
    end
  end

  assign oMemReqValid  = (state == ISSUE);
  assign oMemRespReady = (state == WAIT);
  assign oMemAddr      = addr_p0;
  assign oMemWrEn      = wren_p0;
  assign oMemWrData    = wdata_p0;
  assign oMemWrLen     = wlen_p0;
  assign oIfuRespValid = (state == RESP) && (owner_p0 == OWN_IFU);
  assign oLsuRespValid = (state == RESP) && (owner_p0 == OWN_LSU);
  assign oIfuRespData  = rdata_p1;
  assign oLsuRespData  = rdata_p1;
  assign oBusy         = !idle;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single simulation memory port (DPI memory bridge) between the instruction fetch unit (IFU) and the load/store unit (LSU) of the pipelined core.
- Accepts one request at a time via valid/ready handshakes, forwards it to the memory port, and routes the response back to the owning requester.
- LSU has priority over IFU; a starvation counter forces an IFU grant after a bounded run of LSU grants.

Parameters:
- ADDR_W, 64, address width
- DATA_W, 64, data width
- LSU_BURST_MAX, 4, consecutive LSU grants allowed while IFU waits (≥1)

Ports:
- iClock  in  1  clock
- iResetN  in  1  asynchronous active-low reset
- iIfuReqValid/oIfuReqReady  in/out  1  IFU request handshake
- iIfuAddr  in  ADDR_W  fetch address
- oIfuRespValid/iIfuRespReady  out/in  1  IFU response handshake
- oIfuRespData  out  DATA_W  fetched data
- iLsuReqValid/oLsuReqReady  in/out  1  LSU request handshake
- iLsuAddr  in  ADDR_W  load/store address
- iLsuWrEn  in  1  1 = store
- iLsuWrData  in  DATA_W  store data
- iLsuWrLen  in  8  store byte length
- oLsuRespValid/iLsuRespReady  out/in  1  LSU response handshake
- oLsuRespData  out  DATA_W  load data (don't-care for stores)
- oMemReqValid/iMemReqReady  out/in  1  memory request handshake
- oMemAddr  out  ADDR_W  memory address
- oMemWrEn  out  1  memory write enable
- oMemWrData  out  DATA_W  memory write data
- oMemWrLen  out  8  memory write byte length
- iMemRespValid/oMemRespReady  in/out  1  memory response handshake
- iMemRespData  in  DATA_W  memory read data
- oBusy  out  1  FSM not in IDLE

Behaviour:
- Reset (async, iResetN=0):
  - FSM=IDLE, streak counter=0.
  - All valid/ready outputs 0, all data/address outputs 0.
  - On release, the first request can be accepted in the first clock edge.
- IDLE:
  - oXReqReady=1 only for the granted requester; at most one ready is high.
  - Grant rule:
    - Only one valid: grant it.
    - Both valid: LSU wins unless streak==LSU_BURST_MAX, then IFU wins.
  - On handshake: latch owner, addr, wren, wdata, wlen. IFU requests latch wren=0, wlen=0. Go to ISSUE.
- Streak counter:
  - Cleared on any IFU grant.
  - Increments (saturating at LSU_BURST_MAX) on an LSU grant while iIfuReqValid=1.
  - Otherwise held.
- ISSUE: oMemReqValid=1 with latched fields, held stable until iMemReqReady=1, then go to WAIT.
- WAIT:
  - oMemRespReady=1.
  - On iMemRespValid: capture iMemRespData into the response register, go to RESP.
- RESP:
  - The owner's oXRespValid=1 with the captured data; the other requester's resp valid stays 0.
  - Held until the owner's iXRespReady=1, then go to IDLE.
- Stores also receive a response, acting as a write ack.
- Latency with a zero-wait memory (ready and resp valid same cycle as asserted):
  - Accept at edge N, oMemReqValid visible after N.
  - Response valid two cycles after the request handshake.
  - Minimum 4 cycles from request accept to the next accept.
- No new request is accepted outside IDLE; requesters hold valid (standard valid/ready).
- iMemRespValid outside WAIT is ignored (oMemRespReady=0).
- Reset mid-operation: the transaction is dropped, outputs go to reset values immediately. A late memory response after reset is ignored.
- Latched fields are registered outputs, with no combinational path from requester inputs to oMem*.
- oBusy = (state != IDLE).

Decomposition:
- Shared package:
  - FSM state enum (IDLE, ISSUE, WAIT, RESP)
  - Owner enum (OWN_IFU, OWN_LSU)
  - ADDR_W/DATA_W defaults
  - Write-length width constant (8)
- One natural sub-module: mem_arb_grant, the combinational grant logic plus the streak counter (inputs: both valids, IDLE flag, handshake; output: grant owner). The FSM and datapath latches stay in the top.

Test Plan:
- Reset mid-ISSUE: assert iResetN=0 while oMemReqValid=1 → all outputs 0 asynchronously. After release, a stray iMemRespValid=1 is ignored and the next IFU request is accepted normally.
- IFU-only read: addr 0x80000000, memory returns 0x00000013_00100073 after 0-wait → oIfuRespValid one cycle after the memory response with that data, oLsuRespValid stays 0, 4-cycle turnaround.
- LSU store: addr 0x80001000, data 0xDEADBEEF, len 4, memory ready delayed 3 cycles → oMemReqValid held 4 cycles with stable fields, oMemWrEn=1, oMemWrLen=4, then LSU ack.
- Simultaneous requests held continuously, LSU_BURST_MAX=4 → grant order LSU,LSU,LSU,LSU,IFU,LSU,… and the streak counter returns to 0 after the IFU grant.
- Response backpressure: iLsuRespReady=0 for 5 cycles → oLsuRespValid and data stable, oIfuReqReady=0 throughout, IFU accepted the cycle after the LSU response handshake.
